// File: rtl/phase_pkg.sv
// Shared phase/opcode definitions and the opcode-to-control-mask decode table,
// used by the sequencer and the downstream control-signal combiner.
package phase_pkg;

    localparam int unsigned PH_W = 3;
    localparam int unsigned OP_W = 2;

    localparam logic [PH_W-1:0] PH_IDLE = 3'b000;
    localparam logic [PH_W-1:0] PH_T0   = 3'b001;
    localparam logic [PH_W-1:0] PH_T1   = 3'b010;
    localparam logic [PH_W-1:0] PH_T2   = 3'b100;

    typedef enum logic [OP_W-1:0] {
        OP_LDA = 2'b00,
        OP_LDB = 2'b01,
        OP_ADD = 2'b10,
        OP_OUT = 2'b11
    } opcode_t;

    typedef struct packed {
        logic [PH_W-1:0] ea;
        logic [PH_W-1:0] er;
        logic [PH_W-1:0] la;
        logic [PH_W-1:0] lb;
        logic [PH_W-1:0] lr;
    } ctl_masks_t;

    // Bit i of each mask is the control strobe active during phase Ti.
    function automatic ctl_masks_t decode_op(input opcode_t op);
        ctl_masks_t m;
        m = '0;
        case (op)
            OP_LDA: m.la = PH_T0;
            OP_LDB: m.lb = PH_T0;
            OP_ADD: begin
                m.lr = PH_T1;
                m.er = PH_T2;
                m.la = PH_T2;
            end
            OP_OUT: m.ea = PH_T0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode-to-control-mask decoder.
module op_decode
    import phase_pkg::*;
(
    input  logic [OP_W-1:0] opcode_i,
    output ctl_masks_t      masks_c_o
);

    assign masks_c_o = decode_op(opcode_t'(opcode_i));

endmodule

// File: rtl/phase_sequencer.sv
// Three-phase instruction sequencer: issues T0/T1/T2 timing phases with
// per-phase control masks, supports hold, abort and back-to-back issue.
module phase_sequencer
    import phase_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OP_W-1:0]  opcode,
    input  logic             hold,
    input  logic             abort,
    output logic [PH_W-1:0]  pla,
    output logic [PH_W-1:0]  Ea,
    output logic [PH_W-1:0]  Er,
    output logic [PH_W-1:0]  La,
    output logic [PH_W-1:0]  Lb,
    output logic [PH_W-1:0]  Lr,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] icount
);

    // State encoding equals the one-hot phase so pla is the state register.
    typedef enum logic [PH_W-1:0] {
        S_IDLE = PH_IDLE,
        S_T0   = PH_T0,
        S_T1   = PH_T1,
        S_T2   = PH_T2
    } state_t;

    state_t             state_q, state_d;
    ctl_masks_t         masks_q, masks_d;
    ctl_masks_t         dec_masks_c;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   icount_q, icount_d;

    op_decode u_op_decode (
        .opcode_i  (opcode),
        .masks_c_o (dec_masks_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            masks_q  <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            masks_q  <= masks_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            icount_q <= icount_d;
        end
    end

    // Abort beats hold beats normal sequencing; hold freezes everything incl. done.
    always_comb begin
        state_d  = state_q;
        masks_d  = masks_q;
        done_d   = 1'b0;
        icount_d = icount_q;
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            masks_d = '0;
        end else if (hold) begin
            done_d = done_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_T0;
                        masks_d = dec_masks_c;
                    end
                end
                S_T0: state_d = S_T1;
                S_T1: state_d = S_T2;
                S_T2: begin
                    done_d   = 1'b1;
                    icount_d = icount_q + CNT_W'(1);
                    if (start) begin
                        state_d = S_T0;
                        masks_d = dec_masks_c;
                    end else begin
                        state_d = S_IDLE;
                        masks_d = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    masks_d = '0;
                end
            endcase
        end
        busy_d = |state_d;
    end

    assign pla    = state_q;
    assign Ea     = masks_q.ea;
    assign Er     = masks_q.er;
    assign La     = masks_q.la;
    assign Lb     = masks_q.lb;
    assign Lr     = masks_q.lr;
    assign busy   = busy_q;
    assign done   = done_q;
    assign icount = icount_q;

endmodule
